// File: rtl/timer_pkg.sv
// Shared definitions for the bus-programmable down-counter timer:
// FSM states, register map, CTRL bit positions and MODE encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_PSC    = 2'd3;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Only 01 reloads; 10/11 fall back to one-shot behaviour.
    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// CPU peripheral-bus view of the timer: word-addressed register access plus
// the level interrupt line.
interface timer_ctrl_if #(
    parameter int WIDTH = 32
);

    logic [1:0]       addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             irq;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running 0..psc counter emitting a one-cycle tick on the terminal value;
// clr restarts the count so each LOAD begins a full prescale period.
module timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt;

    assign tick = (cnt == psc);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped down-counter timer with one-shot/auto-reload modes and masked irq.
// Define TIMER_PRESCALE_EN to add the PSC register and tick-gated counting.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    timer_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic             ctrl_en;
    logic             ctrl_im;
    logic [1:0]       ctrl_mode;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nx;
    logic             irq_pending;
    logic [PSC_W-1:0] psc_q;
    logic             tick;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             eff_en;
    logic [1:0]       eff_mode;
    logic             int_entry;
    logic             hw_en_clr;
    logic [WIDTH-1:0] rdata_c;

    assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
    assign wr_preset = bus.we && (bus.addr == ADDR_PRESET);

    // The FSM acts on the CTRL value being written this edge, not the stale one.
    assign eff_en   = wr_ctrl ? bus.wdata[CTRL_EN_BIT] : ctrl_en;
    assign eff_mode = wr_ctrl ? bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB] : ctrl_mode;

`ifdef TIMER_PRESCALE_EN
    logic wr_psc;
    logic psc_clr;

    assign wr_psc  = bus.we && (bus.addr == ADDR_PSC);
    assign psc_clr = (state == LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
        end else if (wr_psc) begin
            psc_q <= bus.wdata[PSC_W-1:0];
        end
    end

    timer_prescaler #(
        .PSC_W(PSC_W)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (psc_clr),
        .psc  (psc_q),
        .tick (tick)
    );
`else
    assign psc_q = '0;
    assign tick  = 1'b1;
`endif

    always_comb begin
        state_nx  = state;
        count_nx  = count_q;
        int_entry = 1'b0;
        hw_en_clr = 1'b0;
        case (state)
            IDLE: begin
                if (eff_en) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                count_nx = preset_q;
                state_nx = CNT;
            end
            CNT: begin
                if (!eff_en) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    if (count_q > WIDTH'(1)) begin
                        count_nx = count_q - WIDTH'(1);
                    end else begin
                        count_nx  = '0;
                        state_nx  = INT;
                        int_entry = 1'b1;
                    end
                end
            end
            INT: begin
                if (is_auto(eff_mode)) begin
                    state_nx = LOAD;
                end else begin
                    state_nx  = IDLE;
                    hw_en_clr = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count_q <= '0;
        end else begin
            state   <= state_nx;
            count_q <= count_nx;
        end
    end

    // A CPU write to CTRL overrides the one-shot hardware clear of EN.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= '0;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= bus.wdata[CTRL_EN_BIT];
            ctrl_mode <= bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
            ctrl_im   <= bus.wdata[CTRL_IM_BIT];
        end else if (hw_en_clr) begin
            ctrl_en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preset_q <= '0;
        end else if (wr_preset) begin
            preset_q <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pending <= 1'b0;
        end else if (int_entry) begin
            irq_pending <= 1'b1;
        end else if (wr_ctrl) begin
            irq_pending <= 1'b0;
        end
    end

    always_comb begin
        rdata_c = '0;
        case (bus.addr)
            ADDR_CTRL:   rdata_c[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
            ADDR_PRESET: rdata_c = preset_q;
            ADDR_COUNT:  rdata_c = count_q;
            ADDR_PSC:    rdata_c = WIDTH'(psc_q);
            default:     rdata_c = '0;
        endcase
    end

    assign bus.rdata = rdata_c;
    assign bus.irq   = irq_pending & ctrl_im;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: randomized runs checked against closed-form
// COUNT/irq timing derived from preset, prescale and mode.
module tb_timer_ctrl;
    import timer_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int unsigned psc_cur = 0;

    timer_ctrl_if #(.WIDTH(WIDTH)) bus ();

    timer_ctrl #(
        .WIDTH(WIDTH),
        .PSC_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.we    = 1'b1;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.addr  = ADDR_COUNT;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
        bus.addr = ADDR_COUNT;
    endtask

    task automatic do_reset();
        bus.we    = 1'b0;
        bus.addr  = ADDR_COUNT;
        bus.wdata = '0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        psc_cur   = 0;
    endtask

    task automatic set_psc(input int unsigned p);
        wr(ADDR_PSC, p);
`ifdef TIMER_PRESCALE_EN
        psc_cur = p;
`else
        psc_cur = 0;
`endif
    endtask

    // Cycles spent counting before INT is entered: max(N,1) values, each held p+1 cycles.
    function automatic int unsigned run_cycles(input int unsigned n, input int unsigned p);
        return ((n == 0) ? 1 : n) * (p + 1);
    endfunction

    // COUNT k edges after the enabling CTRL write (k >= 1).
    function automatic logic [31:0] exp_count(input int unsigned n, input int unsigned k,
                                               input bit auto_mode, input int unsigned p);
        int unsigned d;
        int unsigned c;
        d = run_cycles(n, p);
        c = k - 1;
        if (auto_mode) c = c % (d + 2);
        if (c < d) return n - c / (p + 1);
        return 0;
    endfunction

    function automatic int unsigned rand_psc();
`ifdef TIMER_PRESCALE_EN
        return $urandom_range(0, 3);
`else
        return 0;
`endif
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        rd(ADDR_CTRL, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", d); end
        rd(ADDR_PRESET, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_preset got=%0h exp=0", d); end
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", d); end
        rd(ADDR_PSC, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_psc got=%0h exp=0", d); end
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    endtask

    task automatic test_oneshot();
        logic [1:0]  os_modes [3] = '{2'b00, 2'b10, 2'b11};
        logic [31:0] d;
        for (int it = 0; it < 6; it++) begin
            int unsigned n = $urandom_range(0, 12);
            int unsigned p = rand_psc();
            logic        im = 1'($urandom_range(0, 1));
            logic [1:0]  mode = os_modes[$urandom_range(0, 2)];
            int unsigned dl;
            do_reset();
            set_psc(p);
            wr(ADDR_PRESET, n);
            wr(ADDR_CTRL, {28'd0, im, mode, 1'b1});
            dl = run_cycles(n, psc_cur);
            for (int unsigned k = 1; k <= dl + 4; k++) begin
                logic exp_irq;
                step();
                rd(ADDR_COUNT, d);
                checks++;
                if (d !== exp_count(n, k, 1'b0, psc_cur)) begin
                    failures++;
                    $display("FAIL oneshot_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, exp_count(n, k, 1'b0, psc_cur));
                end
                exp_irq = (k >= dl + 1) && im;
                checks++;
                if (bus.irq !== exp_irq) begin
                    failures++;
                    $display("FAIL oneshot_irq n=%0d k=%0d got=%b exp=%b", n, k, bus.irq, exp_irq);
                end
            end
            rd(ADDR_CTRL, d);
            checks++;
            if (d !== {28'd0, im, mode, 1'b0}) begin
                failures++; $display("FAIL oneshot_en_clear got=%0h exp=%0h", d, {28'd0, im, mode, 1'b0});
            end
            wr(ADDR_CTRL, {28'd0, 1'b1, mode, 1'b0});
            checks++;
            if (bus.irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_clear got=%b exp=0", bus.irq); end
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        for (int it = 0; it < 4; it++) begin
            int unsigned n = $urandom_range(0, 8);
            int unsigned p = rand_psc();
            int unsigned dl;
            int unsigned kend;
            do_reset();
            set_psc(p);
            wr(ADDR_PRESET, n);
            wr(ADDR_CTRL, 32'hB);
            dl   = run_cycles(n, psc_cur);
            kend = 3 * (dl + 2);
            for (int unsigned k = 1; k <= kend; k++) begin
                logic exp_irq;
                step();
                rd(ADDR_COUNT, d);
                checks++;
                if (d !== exp_count(n, k, 1'b1, psc_cur)) begin
                    failures++;
                    $display("FAIL auto_count n=%0d k=%0d got=%0d exp=%0d", n, k, d, exp_count(n, k, 1'b1, psc_cur));
                end
                exp_irq = (k >= dl + 1);
                checks++;
                if (bus.irq !== exp_irq) begin
                    failures++;
                    $display("FAIL auto_irq n=%0d k=%0d got=%b exp=%b", n, k, bus.irq, exp_irq);
                end
            end
            wr(ADDR_CTRL, 32'hB);
            checks++;
            if (bus.irq !== 1'b0) begin failures++; $display("FAIL auto_irq_clear got=%b exp=0", bus.irq); end
            rd(ADDR_COUNT, d);
            checks++;
            if (d !== exp_count(n, kend + 1, 1'b1, psc_cur)) begin
                failures++;
                $display("FAIL auto_count_after_rewrite got=%0d exp=%0d", d, exp_count(n, kend + 1, 1'b1, psc_cur));
            end
            wr(ADDR_CTRL, 32'h0);
        end
    endtask

    task automatic test_mask_abort();
        logic [31:0] d;
        do_reset();
        wr(ADDR_PRESET, 4);
        wr(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (bus.irq !== 1'b0) begin failures++; $display("FAIL mask_irq k=%0d got=%b exp=0", k, bus.irq); end
        end
        rd(ADDR_CTRL, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mask_ctrl got=%0h exp=0", d); end

        do_reset();
        wr(ADDR_PRESET, 10);
        wr(ADDR_CTRL, 32'h9);
        repeat (4) step();
        wr(ADDR_CTRL, 32'h0);
        repeat (3) step();
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd7) begin failures++; $display("FAIL abort_count_hold got=%0d exp=7", d); end
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL abort_irq got=%b exp=0", bus.irq); end
    endtask

    task automatic test_preset_zero();
        logic [31:0] d;
        do_reset();
        wr(ADDR_PRESET, 0);
        wr(ADDR_CTRL, 32'h9);
        step();
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL pz_irq_early got=%b exp=0", bus.irq); end
        step();
        checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL pz_irq got=%b exp=1", bus.irq); end
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL pz_count got=%0d exp=0", d); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        do_reset();
        wr(ADDR_PRESET, 5);
        wr(ADDR_CTRL, 32'hB);
        repeat (4) step();
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL rmc_pre_count got=%0d exp=2", d); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rmc_count got=%0d exp=0", d); end
        rd(ADDR_CTRL, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rmc_ctrl got=%0h exp=0", d); end
        rd(ADDR_PRESET, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rmc_preset got=%0d exp=0", d); end
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL rmc_irq got=%b exp=0", bus.irq); end
        wr(ADDR_PRESET, 9);
        repeat (3) step();
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rmc_idle_count got=%0d exp=0", d); end
    endtask

    task automatic test_preset_rewrite();
        logic [31:0] d;
        do_reset();
        wr(ADDR_PRESET, 3);
        wr(ADDR_CTRL, 32'hB);
        repeat (2) step();
        wr(ADDR_PRESET, 7);
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL prw_k3 got=%0d exp=1", d); end
        step();
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL prw_k4 got=%0d exp=0", d); end
        repeat (2) step();
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd7) begin failures++; $display("FAIL prw_reload got=%0d exp=7", d); end
        wr(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_collision_auto();
        logic [31:0] d;
        do_reset();
        wr(ADDR_PRESET, 2);
        wr(ADDR_CTRL, 32'hB);
        repeat (2) step();
        wr(ADDR_CTRL, 32'hB);
        checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL coll_auto_set got=%b exp=1", bus.irq); end
        wr(ADDR_CTRL, 32'hB);
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL coll_auto_clear got=%b exp=0", bus.irq); end
        step();
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL coll_auto_reload got=%0d exp=2", d); end
        wr(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_collision_oneshot();
        logic [31:0] d;
        do_reset();
        wr(ADDR_PRESET, 2);
        wr(ADDR_CTRL, 32'h9);
        repeat (3) step();
        checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL coll_os_int got=%b exp=1", bus.irq); end
        wr(ADDR_CTRL, 32'h9);
        rd(ADDR_CTRL, d);
        checks++; if (d !== 32'h9) begin failures++; $display("FAIL coll_os_en got=%0h exp=9", d); end
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL coll_os_irq_clr got=%b exp=0", bus.irq); end
        repeat (2) step();
        rd(ADDR_COUNT, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL coll_os_rerun got=%0d exp=2", d); end
        repeat (2) step();
        checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL coll_os_irq2 got=%b exp=1", bus.irq); end
        step();
        rd(ADDR_CTRL, d);
        checks++; if (d !== 32'h8) begin failures++; $display("FAIL coll_os_done got=%0h exp=8", d); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        do_reset();
        wr(ADDR_PSC, 2);
        rd(ADDR_PSC, d);
`ifdef TIMER_PRESCALE_EN
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL psc_readback got=%0d exp=2", d); end
        psc_cur = 2;
`else
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL psc_ignored got=%0d exp=0", d); end
        psc_cur = 0;
`endif
        wr(ADDR_PRESET, 2);
        wr(ADDR_CTRL, 32'h9);
        for (int unsigned k = 1; k <= 3 * (psc_cur + 1) + 1; k++) begin
            logic exp_irq;
            step();
            rd(ADDR_COUNT, d);
            checks++;
            if (d !== exp_count(2, k, 1'b0, psc_cur)) begin
                failures++;
                $display("FAIL psc_count k=%0d got=%0d exp=%0d", k, d, exp_count(2, k, 1'b0, psc_cur));
            end
            exp_irq = (k >= 2 * (psc_cur + 1) + 1);
            checks++;
            if (bus.irq !== exp_irq) begin
                failures++;
                $display("FAIL psc_irq k=%0d got=%b exp=%b", k, bus.irq, exp_irq);
            end
        end
    endtask

    initial begin
        bus.addr  = ADDR_COUNT;
        bus.we    = 1'b0;
        bus.wdata = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask_abort();
        test_preset_zero();
        test_reset_midcount();
        test_preset_rewrite();
        test_collision_auto();
        test_collision_oneshot();
        test_prescale();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
